ifetch_stage: RTL and testbench

// - Fetch stage: the producer side of the InstrF/PCPlus8/stall interface that the decode stage consumes.
// - Holds the PC and issues word reads to instruction memory over a req/ack handshake.
// - Buffers returned words in a small prefetch queue and presents one instruction per cycle to decode.
// - Presents a NOP bubble when the queue is empty; handles branch redirects by flushing the queue.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/ifetch_stage_if.sv | 10 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/ifetch_stage.sv | 74 +++++++
 tb/tb_ifetch_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch types and constants (NOP_INSTR, WORD, fetch_entry_t)
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;
  localparam int WORD = 32;
  typedef struct packed {
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: imem read handshake (req, addr out of fetch; ack, rdata back), modports master=fetch, slave=memory
interface ifetch_stage_if;
  import cpu_pkg::*;
  logic req;
  logic [WORD-1:0] addr;
  logic ack;
  logic [WORD-1:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue (clk, rst, flush, push/din, pop/dout head, full, empty, count), flush and rst synchronous
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    dout = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: fetch stage (clk, reset, stall, PCSrcW, BranchTargetW, imem master port, InstrF/PCPlus8/InstrValidF to decode; IFETCH_STATS_EN adds bubble_cnt/flush_cnt)
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic PCSrcW,
  input  logic [WORD-1:0] BranchTargetW,
  ifetch_stage_if.master imem,
  output logic [WORD-1:0] InstrF,
  output logic [WORD-1:0] PCPlus8,
  output logic InstrValidF
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic [WORD-1:0] pc, req_pc;
  logic outstanding, drop, issue, push, pop, full, empty;
  logic [OW-1:0] occ;
  fetch_entry_t head;
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(PCSrcW),
    .push(push),
    .pop(pop),
    .din('{instr: imem.rdata, pc: req_pc}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occ)
  );
  always_comb begin
    issue = !reset && !outstanding && !drop && occ < OW'(DEPTH);
    imem.req = issue;
    imem.addr = pc;
    push = imem.ack && outstanding && !drop && !PCSrcW && !full;
    pop = !stall && !empty;
    InstrValidF = !empty;
    InstrF = empty ? NOP_INSTR : head.instr;
    PCPlus8 = (empty ? pc : head.pc) + 32'd8;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= {RESET_PC[31:2], 2'b00};
      req_pc <= {RESET_PC[31:2], 2'b00};
      outstanding <= 1'b0;
      drop <= 1'b0;
    end else begin
      outstanding <= issue || (outstanding && !imem.ack);
      drop <= PCSrcW ? (issue || (outstanding && !imem.ack)) : drop && !imem.ack;
      if (issue) req_pc <= pc;
      pc <= PCSrcW ? {BranchTargetW[31:2], 2'b00} : issue ? pc + 32'd4 : pc;
    end
  end
`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!stall && empty) bubble_cnt <= bubble_cnt + 32'd1;
      if (PCSrcW) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: scoreboard bench for ifetch_stage with a latency-configurable memory model
module tb_ifetch_stage;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, PCSrcW = 1'b0;
  logic [31:0] BranchTargetW = '0;
  logic [31:0] InstrF, PCPlus8;
  logic InstrValidF;
`ifdef IFETCH_STATS_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif
  ifetch_stage_if imem();
  ifetch_stage #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .PCSrcW(PCSrcW),
    .BranchTargetW(BranchTargetW),
    .imem(imem),
    .InstrF(InstrF),
    .PCPlus8(PCPlus8),
    .InstrValidF(InstrValidF)
`ifdef IFETCH_STATS_EN
    ,
    .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [63:0] sb[$];
  bit mem_pending;
  int mem_cnt, mem_lat = 1, bubble_m, flush_m;
  logic [31:0] mem_addr, exp_addr;
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h5A00_0000 + a;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic mem_update();
    imem.ack = 1'b0;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem.ack = 1'b1;
        imem.rdata = word(mem_addr);
        mem_pending = 1'b0;
      end
    end
    if (imem.req) begin
      check("req_addr", imem.addr, exp_addr);
      mem_pending = 1'b1;
      mem_cnt = mem_lat;
      mem_addr = imem.addr;
      sb.push_back({word(imem.addr), imem.addr + 32'd8});
      exp_addr = exp_addr + 32'd4;
    end
  endtask
  task automatic step(input logic s, input logic p, input logic [31:0] t);
    if (!InstrValidF) check("bubble_instr", InstrF, NOP_INSTR);
    else if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      check("instr", InstrF, sb[0][63:32]);
      check("pc8", PCPlus8, sb[0][31:0]);
      if (!s && !p) void'(sb.pop_front());
    end
    if (mem_pending) check("one_outstanding", {31'd0, imem.req}, 32'd0);
    if (!s && !InstrValidF) bubble_m++;
    if (p) flush_m++;
    stall = s;
    PCSrcW = p;
    BranchTargetW = t;
    mem_update();
    if (p) begin
      sb.delete();
      exp_addr = t;
    end
  endtask
  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step(s, 1'b0, 32'h0);
    end
  endtask
  task automatic wait_valid(input string tag, input logic [31:0] ei, input logic [31:0] ep);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (InstrValidF) begin
        check({tag, "_instr"}, InstrF, ei);
        check({tag, "_pc8"}, PCPlus8, ep);
        step(1'b0, 1'b0, 32'h0);
        return;
      end
      step(1'b0, 1'b0, 32'h0);
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    PCSrcW = 1'b0;
    BranchTargetW = '0;
    imem.ack = 1'b0;
    mem_pending = 1'b0;
    sb.delete();
    exp_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_valid", {31'd0, InstrValidF}, 32'd0);
    check("rst_instr", InstrF, NOP_INSTR);
    check("rst_pc8", PCPlus8, 32'd8);
`ifdef IFETCH_STATS_EN
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    bubble_m = 0;
    flush_m = 0;
    reset = 1'b0;
    #1;
    if (!InstrValidF) bubble_m++;
    mem_update();
  endtask
  initial begin
    bit found;
    imem.ack = 1'b0;
    imem.rdata = '0;
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 3; k++) wait_valid("seq", word(32'(4 * k)), 32'(4 * k + 8));
    run(5, 1'b1);
    @(negedge clk);
    check("full_req", {31'd0, imem.req}, 32'd0);
    check("full_valid", {31'd0, InstrValidF}, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    run(10, 1'b0);
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_pending && mem_cnt >= 2) begin
        found = 1'b1;
        step(1'b0, 1'b1, 32'h100);
      end else step(1'b0, 1'b0, 32'h0);
    end
    check("drop_setup", {31'd0, found}, 32'd1);
    wait_valid("redirect", word(32'h100), 32'h108);
    mem_lat = 1;
    run(6, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (mem_pending && mem_cnt == 1 && InstrValidF) begin
        found = 1'b1;
        step(1'b0, 1'b1, 32'h200);
      end else step(1'b1, 1'b0, 32'h0);
    end
    check("ack_pop_setup", {31'd0, found}, 32'd1);
    @(negedge clk);
    check("flush_empty", {31'd0, InstrValidF}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    wait_valid("after_flush", word(32'h200), 32'h208);
    mem_lat = 4;
    run(40, 1'b0);
    run(3, 1'b1);
    run(10, 1'b0);
    mem_lat = 1;
    run(10, 1'b0);
`ifdef IFETCH_STATS_EN
    @(negedge clk);
    check("bubble_cnt", bubble_cnt, 32'(bubble_m));
    check("flush_cnt", flush_cnt, 32'(flush_m));
    step(1'b0, 1'b0, 32'h0);
`endif
    do_reset();
    wait_valid("post_reset", word(32'h0), 32'h8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
